simple_axi_cmd_queue: RTL and testbench

//  Upstream feeder for simple_axi_master. Buffers host commands in a DEPTH-entry FIFO.

---
 rtl/simple_axi_cmd_queue.sv | 147 ++++++++++++++
 tb/tb_simple_axi_cmd_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_axi_cmd_queue.sv
// Command FIFO and sequencer feeding simple_axi_master: issues one queued command at a time,
// waits for completion, pulses clear, then returns an in-order response.
module simple_axi_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     s_cmd_valid,
  output logic                     s_cmd_ready,
  input  logic                     s_cmd_rw,
  input  logic [2:0]               s_cmd_size,
  input  logic [AW-1:0]            s_cmd_addr,
  input  logic [DW-1:0]            s_cmd_wdata,
  output logic                     m_rsp_valid,
  input  logic                     m_rsp_ready,
  output logic                     m_rsp_rw,
  output logic [1:0]               m_rsp_status,
  output logic [DW-1:0]            m_rsp_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy,
  output logic [2:0]               o_size,
  output logic [AW-1:0]            o_addr,
  output logic [DW-1:0]            o_wdata,
  output logic [1:0]               o_rw,
  output logic                     o_clear,
  input  logic                     i_wait,
  input  logic                     i_done,
  input  logic                     i_error,
  input  logic                     i_invalid,
  input  logic [DW-1:0]            i_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic          rw;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR, S_RESP} state_t;

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_cur_rw;
  state_t        r_state, w_next;
  logic          w_push, w_pop, w_issue, w_fire, w_flag;
  cmd_t          w_head;
  logic          w_unused_wait;

  // Master wait is informational only; sequencing keys off the completion flags.
  assign w_unused_wait = i_wait;

  assign s_cmd_ready = !i_rst && (r_level < LW'(DEPTH));
  assign w_push      = s_cmd_valid && s_cmd_ready;
  assign w_head      = r_mem[r_rptr];
  assign w_flag      = i_done || i_error || i_invalid;
  assign o_level     = r_level;
  assign o_busy      = (r_state != S_IDLE);

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_pop   = 1'b0;
    w_fire  = 1'b0;
    case (r_state)
      // Stale flags from the previous command must drop before the next issue.
      S_IDLE:  if (r_level != '0 && !m_rsp_valid && !w_flag) begin
                 w_next  = S_ISSUE;
                 w_issue = 1'b1;
               end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_flag) begin
                 w_next = S_CLEAR;
                 w_pop  = 1'b1;
               end
      S_CLEAR: w_next = S_RESP;
      S_RESP:  if (m_rsp_ready) begin
                 w_next = S_IDLE;
                 w_fire = 1'b1;
               end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {s_cmd_rw, s_cmd_size, s_cmd_addr, s_cmd_wdata};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rw         <= 2'b00;
      o_addr       <= '0;
      o_size       <= '0;
      o_wdata      <= '0;
      o_clear      <= 1'b0;
      r_cur_rw     <= 1'b0;
      m_rsp_valid  <= 1'b0;
      m_rsp_rw     <= 1'b0;
      m_rsp_status <= 2'b00;
      m_rsp_rdata  <= '0;
    end else begin
      if (w_issue) begin
        o_addr   <= w_head.addr;
        o_size   <= w_head.size;
        o_wdata  <= w_head.wdata;
        o_rw     <= w_head.rw ? 2'b10 : 2'b01;
        r_cur_rw <= w_head.rw;
      end
      if (w_pop) begin
        o_rw         <= 2'b00;
        o_clear      <= 1'b1;
        m_rsp_rw     <= r_cur_rw;
        m_rsp_status <= i_invalid ? 2'b10 : (i_error ? 2'b01 : 2'b00);
        m_rsp_rdata  <= r_cur_rw ? '0 : i_rdata;
      end
      if (r_state == S_CLEAR) begin
        o_clear     <= 1'b0;
        m_rsp_valid <= 1'b1;
      end
      if (w_fire) m_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simple_axi_cmd_queue.sv
// Directed bench for simple_axi_cmd_queue with a behavioural master responder and
// issue/response scoreboards.
module tb_simple_axi_cmd_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 64;

  logic                   i_clk, i_rst;
  logic                   s_cmd_valid, s_cmd_ready, s_cmd_rw;
  logic [2:0]             s_cmd_size;
  logic [AW-1:0]          s_cmd_addr;
  logic [DW-1:0]          s_cmd_wdata;
  logic                   m_rsp_valid, m_rsp_ready, m_rsp_rw;
  logic [1:0]             m_rsp_status;
  logic [DW-1:0]          m_rsp_rdata;
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_busy, o_clear;
  logic [2:0]             o_size;
  logic [AW-1:0]          o_addr;
  logic [DW-1:0]          o_wdata;
  logic [1:0]             o_rw;
  logic                   i_wait, i_done, i_error, i_invalid;
  logic [DW-1:0]          i_rdata;

  simple_axi_cmd_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_rw(s_cmd_rw),
    .s_cmd_size(s_cmd_size), .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rw(m_rsp_rw),
    .m_rsp_status(m_rsp_status), .m_rsp_rdata(m_rsp_rdata),
    .o_level(o_level), .o_busy(o_busy), .o_size(o_size), .o_addr(o_addr),
    .o_wdata(o_wdata), .o_rw(o_rw), .o_clear(o_clear),
    .i_wait(i_wait), .i_done(i_done), .i_error(i_error), .i_invalid(i_invalid),
    .i_rdata(i_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int lat    = 2;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {logic rw; logic [1:0] st; logic [DW-1:0] rd;} rsp_t;
  typedef struct {logic [1:0] rw; logic [2:0] sz; logic [AW-1:0] ad; logic [DW-1:0] wd;} iss_t;
  rsp_t rsp_q[$];
  iss_t iss_q[$];

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 32'h2008) return 64'h0123456789ABCDEF;
    return {a, ~a};
  endfunction

  function automatic logic [1:0] st_model(input logic [AW-1:0] a);
    if (a == 32'h3000) return 2'b10;
    if (a == 32'h3008) return 2'b01;
    return 2'b00;
  endfunction

  // Master model: completes lat cycles after o_rw goes active, drops flags on o_clear.
  initial begin
    int cnt;
    cnt = 0;
    i_done = 0; i_error = 0; i_invalid = 0; i_rdata = '0; i_wait = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst || o_clear) begin
        i_done = 0; i_error = 0; i_invalid = 0; cnt = 0;
      end else if (o_rw != 2'b00) begin
        cnt++;
        if (cnt >= lat) begin
          i_error   = (o_addr == 32'h3000) || (o_addr == 32'h3008);
          i_invalid = (o_addr == 32'h3000);
          i_done    = !(i_error || i_invalid);
          i_rdata   = (o_rw == 2'b01) ? rd_model(o_addr) : '1;
        end
      end
      i_wait = (o_rw != 2'b00) && !i_done;
    end
  end

  // Issue monitor: operands checked on each rising o_rw.
  initial begin
    logic [1:0] prev_rw;
    iss_t e;
    prev_rw = 2'b00;
    forever begin
      @(negedge i_clk);
      if (i_rst) prev_rw = 2'b00;
      else begin
        if (o_rw != 2'b00 && prev_rw == 2'b00) begin
          chk("issue_expected", iss_q.size() > 0, 1'b1);
          if (iss_q.size() > 0) begin
            e = iss_q.pop_front();
            chk("issue_rw", o_rw, e.rw);
            chk("issue_addr", o_addr, e.ad);
            chk("issue_size", o_size, e.sz);
            chk("issue_wdata", o_wdata, e.wd);
          end
        end
        prev_rw = o_rw;
      end
    end
  end

  // Response monitor and clear-width check.
  initial begin
    logic prev_clr;
    rsp_t e;
    prev_clr = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) prev_clr = 1'b0;
      else begin
        if (prev_clr) chk("clear_width", o_clear, 1'b0);
        prev_clr = o_clear;
        if (m_rsp_valid && m_rsp_ready) begin
          chk("rsp_expected", rsp_q.size() > 0, 1'b1);
          if (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            chk("rsp_rw", m_rsp_rw, e.rw);
            chk("rsp_status", m_rsp_status, e.st);
            chk("rsp_rdata", m_rsp_rdata, e.rd);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic rw, input logic [2:0] sz, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    int t;
    rsp_t r;
    iss_t s;
    t = 0;
    s_cmd_valid = 1; s_cmd_rw = rw; s_cmd_size = sz; s_cmd_addr = a; s_cmd_wdata = wd;
    while (!s_cmd_ready && t < 200) begin
      step();
      t++;
    end
    chk("push_timeout", t < 200, 1'b1);
    s.rw = rw ? 2'b10 : 2'b01; s.sz = sz; s.ad = a; s.wd = wd;
    r.rw = rw; r.st = st_model(a); r.rd = rw ? '0 : rd_model(a);
    iss_q.push_back(s);
    rsp_q.push_back(r);
    step();
    s_cmd_valid = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || o_busy || o_level != 0) && t < 500) begin
      step();
      t++;
    end
    chk("drain_timeout", t < 500, 1'b1);
    chk("drain_issue_q", iss_q.size(), 0);
  endtask

  initial begin
    int t;
    i_rst = 1; s_cmd_valid = 0; s_cmd_rw = 0; s_cmd_size = '0; s_cmd_addr = '0;
    s_cmd_wdata = '0; m_rsp_ready = 1;
    repeat (3) step();
    chk("rst_rw", o_rw, 2'b00);
    chk("rst_clear", o_clear, 1'b0);
    chk("rst_rsp_valid", m_rsp_valid, 1'b0);
    chk("rst_level", o_level, 3'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", s_cmd_ready, 1'b0);
    chk("rst_addr", o_addr, 32'h0);
    i_rst = 0;
    #1;
    chk("ready_after_rst", s_cmd_ready, 1'b1);
    step();

    // single write: o_rw one cycle after accept
    push(1'b1, 3'd3, 32'h1000, 64'hDEADBEEF_CAFEF00D);
    chk("wr_lat_e0", o_rw, 2'b00);
    step();
    chk("wr_lat_e1", o_rw, 2'b10);
    chk("wr_busy", o_busy, 1'b1);
    drain();

    // single read
    push(1'b0, 3'd3, 32'h2008, 64'h0);
    drain();

    // fill: slow master so the FIFO fills
    lat = 30;
    for (int i = 0; i < 4; i++) push(1'b0, 3'd3, AW'(i * 8), 64'h0);
    chk("fill_level", o_level, 3'd4);
    chk("fill_ready", s_cmd_ready, 1'b0);
    push(1'b0, 3'd3, 32'd32, 64'h0);
    lat = 2;
    drain();

    // invalid+error together, then error only
    push(1'b1, 3'd2, 32'h3000, 64'h1111);
    push(1'b1, 3'd2, 32'h3008, 64'h2222);
    drain();

    // response backpressure
    m_rsp_ready = 0;
    for (int i = 0; i < 3; i++) push(1'b1, 3'd2, 32'h4000 + AW'(i * 16), 64'hA0 + DW'(i));
    repeat (20) step();
    chk("bp_rw_idle", o_rw, 2'b00);
    chk("bp_rsp_valid", m_rsp_valid, 1'b1);
    chk("bp_level", o_level, 3'd2);
    push(1'b0, 3'd1, 32'h4030, 64'h0);
    chk("bp_level_accept", o_level, 3'd3);
    chk("bp_rw_still_idle", o_rw, 2'b00);
    m_rsp_ready = 1;
    drain();

    // reset while waiting on the master
    lat = 50;
    push(1'b0, 3'd3, 32'h5000, 64'h0);
    t = 0;
    while (o_rw != 2'b01 && t < 50) begin
      step();
      t++;
    end
    chk("rstwait_issue", o_rw, 2'b01);
    repeat (3) step();
    i_rst = 1;
    #1;
    chk("rstwait_rw", o_rw, 2'b00);
    chk("rstwait_level", o_level, 3'd0);
    chk("rstwait_rsp_valid", m_rsp_valid, 1'b0);
    chk("rstwait_busy", o_busy, 1'b0);
    rsp_q.delete();
    iss_q.delete();
    step();
    i_rst = 0;
    lat = 2;
    repeat (30) step();
    chk("rstwait_no_rsp", m_rsp_valid, 1'b0);
    chk("rstwait_idle", o_busy, 1'b0);

    // recovery after reset
    push(1'b0, 3'd3, 32'h6000, 64'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
